// File: rtl/fpu_mult_arbiter.sv
// Shares one combinational FP32 multiplier among NUM_REQ requesters: IDLE->EXEC->RESP, result 2 cycles after accept.
// Requests are stalled (req_ready low) while busy; the response holds until its owner accepts it. `FPU_MULT_ARB_RR_EN` selects round-robin.

module fp32_mul (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_p
);
   logic              w_sign;
   logic [7:0]        w_ea;
   logic [7:0]        w_eb;
   logic              w_a_zero;
   logic              w_b_zero;
   logic              w_a_inf;
   logic              w_b_inf;
   logic              w_a_nan;
   logic              w_b_nan;
   logic [47:0]       w_prod;
   logic signed [9:0] w_exp;
   logic signed [9:0] w_exp_fin;
   logic [22:0]       w_mant;
   logic              w_guard;
   logic              w_sticky;
   logic              w_inc;
   logic [23:0]       w_mant_rnd;

   assign w_sign   = i_a[31] ^ i_b[31];
   assign w_ea     = i_a[30:23];
   assign w_eb     = i_b[30:23];
   // Subnormal operands are treated as zero and tiny results flush to zero.
   assign w_a_zero = (w_ea == 8'd0);
   assign w_b_zero = (w_eb == 8'd0);
   assign w_a_inf  = (w_ea == 8'hFF) && (i_a[22:0] == 23'd0);
   assign w_b_inf  = (w_eb == 8'hFF) && (i_b[22:0] == 23'd0);
   assign w_a_nan  = (w_ea == 8'hFF) && (i_a[22:0] != 23'd0);
   assign w_b_nan  = (w_eb == 8'hFF) && (i_b[22:0] != 23'd0);
   assign w_prod   = {24'd0, 1'b1, i_a[22:0]} * {24'd0, 1'b1, i_b[22:0]};
   assign w_exp    = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;

   always_comb begin
      if (w_prod[47]) begin
         w_mant    = w_prod[46:24];
         w_guard   = w_prod[23];
         w_sticky  = |w_prod[22:0];
         w_exp_fin = w_exp + 10'sd1;
      end else begin
         w_mant    = w_prod[45:23];
         w_guard   = w_prod[22];
         w_sticky  = |w_prod[21:0];
         w_exp_fin = w_exp;
      end
      // Round to nearest, ties to even.
      w_inc      = w_guard & (w_sticky | w_mant[0]);
      w_mant_rnd = {1'b0, w_mant} + {23'd0, w_inc};
      if (w_mant_rnd[23]) begin
         w_exp_fin = w_exp_fin + 10'sd1;
      end

      if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
         o_p = 32'h7FC0_0000;
      end else if (w_a_inf || w_b_inf) begin
         o_p = {w_sign, 8'hFF, 23'd0};
      end else if (w_a_zero || w_b_zero) begin
         o_p = {w_sign, 31'd0};
      end else if (w_exp_fin >= 10'sd255) begin
         o_p = {w_sign, 8'hFF, 23'd0};
      end else if (w_exp_fin <= 10'sd0) begin
         o_p = {w_sign, 31'd0};
      end else begin
         o_p = {w_sign, w_exp_fin[7:0], w_mant_rnd[22:0]};
      end
   end
endmodule

module fpu_mult_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [NUM_REQ-1:0]     i_req_valid,
   output logic [NUM_REQ-1:0]     o_req_ready,
   input  logic [NUM_REQ*32-1:0]  i_req_a,
   input  logic [NUM_REQ*32-1:0]  i_req_b,
   output logic [NUM_REQ-1:0]     o_resp_valid,
   input  logic [NUM_REQ-1:0]     i_resp_ready,
   output logic [31:0]            o_resp_result,
   output logic                   o_busy,
   output logic [15:0]            o_op_count
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t               r_state;
   logic [IW-1:0]        r_idx;
   logic [31:0]          r_a;
   logic [31:0]          r_b;
   logic [31:0]          r_result;
   logic [NUM_REQ-1:0]   r_resp_valid;
   logic [15:0]          r_op_count;
`ifdef FPU_MULT_ARB_RR_EN
   logic [IW-1:0]        r_ptr;
   int                   w_cand;
`endif

   logic                 w_any;
   logic [IW-1:0]        w_gnt_idx;
   logic                 w_req_fire;
   logic                 w_resp_fire;
   logic [31:0]          w_sel_a;
   logic [31:0]          w_sel_b;
   logic [NUM_REQ-1:0]   w_idx_oh;
   logic [31:0]          w_product;

   fp32_mul u_mul (
      .i_a (r_a),
      .i_b (r_b),
      .o_p (w_product)
   );

   always_comb begin
      w_any     = 1'b0;
      w_gnt_idx = '0;
`ifdef FPU_MULT_ARB_RR_EN
      w_cand    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = (int'(r_ptr) + k) % NUM_REQ;
         if (!w_any && i_req_valid[IW'(w_cand)]) begin
            w_any     = 1'b1;
            w_gnt_idx = IW'(w_cand);
         end
      end
`else
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_any && i_req_valid[k]) begin
            w_any     = 1'b1;
            w_gnt_idx = IW'(k);
         end
      end
`endif
   end

   // Grant is combinational so the winner sees req_ready in the cycle it asks.
   assign w_req_fire  = !i_rst && (r_state == S_IDLE) && w_any;
   assign w_resp_fire = (r_state == S_RESP) && i_resp_ready[r_idx];

   always_comb begin
      o_req_ready = '0;
      w_idx_oh    = '0;
      w_sel_a     = '0;
      w_sel_b     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (IW'(k) == w_gnt_idx) begin
            o_req_ready[k] = w_req_fire;
            w_sel_a        = i_req_a[k*32 +: 32];
            w_sel_b        = i_req_b[k*32 +: 32];
         end
         if (IW'(k) == r_idx) begin
            w_idx_oh[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_result     <= '0;
         r_resp_valid <= '0;
         r_op_count   <= '0;
`ifdef FPU_MULT_ARB_RR_EN
         r_ptr        <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req_fire) begin
                  r_a     <= w_sel_a;
                  r_b     <= w_sel_b;
                  r_idx   <= w_gnt_idx;
                  r_state <= S_EXEC;
`ifdef FPU_MULT_ARB_RR_EN
                  r_ptr   <= (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IW'(1);
`endif
               end
            end
            S_EXEC: begin
               r_result     <= w_product;
               r_resp_valid <= w_idx_oh;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               if (w_resp_fire) begin
                  r_resp_valid <= '0;
                  r_op_count   <= r_op_count + 16'd1;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_resp_valid  = r_resp_valid;
   assign o_resp_result = r_result;
   assign o_busy        = (r_state != S_IDLE);
   assign o_op_count    = r_op_count;
endmodule
